mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 5-stage RV32I core.
- Sits directly downstream of EX_MEM and consumes its outputs: alu_result, reg_2_data, width, sign-extend, reg_src, mem_write, reg_write, rd, advance_pc.
- Drives a word-wide data-memory port with a req/ready handshake, and stalls the upstream pipeline while memory is busy.
- Performs byte/half lane alignment, then registers the final writeback value, rd and write-enable for the register file.

Parameters:
- TIMEOUT, 255: max cycles to wait for dmem_ready_i before aborting the access; legal range 1..1023.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- advance_pc_i  in  32  PC+4 from EX_MEM (link value)
- alu_result_i  in  32  ALU result / effective address
- reg_2_data_i  in  32  store data (rs2)
- reg_write_i  in  1  instruction writes rd
- reg_write_data_addr_i  in  5  rd
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_sign_extend_i  in  1  1 = sign-extend loads
- reg_src_i  in  2  00 ALU, 01 memory, 10 advance_pc, 11 ALU
- mem_write_i  in  1  store
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  write strobe
- dmem_addr_o  out  32  {alu_result_i[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ready_i  in  1  access complete this cycle
- dmem_rdata_i  in  32  read word, valid with ready
- stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM
- wb_reg_write_o  out  1  register-file write enable
- wb_addr_o  out  5  register-file rd
- wb_data_o  out  32  register-file data
- misalign_o  out  1  one-cycle pulse on misaligned/illegal access
- bus_err_o  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async, rst_n low): state IDLE; wait counter 0; all registered outputs 0.
- Memory op definition:
  - mem_op = mem_write_i | (reg_src_i==01).
  - A bubble (mem_op=0, reg_write_i=0) passes through as wb_reg_write_o=0.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or width 11.
  - No dmem_req_o.
  - misalign_o pulses the same cycle.
  - Next cycle wb_reg_write_o=0.
  - No stall.
- FSM states IDLE and WAIT.
  - IDLE with aligned mem_op: dmem_req_o=1 combinationally.
    - If dmem_ready_i=1: complete in this cycle, no stall.
    - Otherwise: stall_o=1, go to WAIT, counter=1.
  - WAIT: dmem_req_o=1, stall_o=1, counter increments each cycle.
    - On ready: stall_o=0 in that cycle, then IDLE.
    - If counter reaches TIMEOUT without ready: abort, set bus_err_o, wb_reg_write_o=0 next cycle, go to IDLE, stall_o=0.
  - Ready arriving in the timeout cycle wins over the timeout.
- Upstream holds EX_MEM inputs stable while stall_o=1; the block does not re-latch them.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100
  - word: 1111
  - dmem_be_o=0000 when no request.
- Store data: byte replicated x4, half replicated x2.
- Load extraction:
  - Select the byte/half lane by addr[1:0].
  - Zero- or sign-extend per mem_sign_extend_i.
  - Word loads ignore the extend flag.
- Writeback mux: reg_src 00/11 alu_result, 01 aligned load data, 10 advance_pc.
- MEM/WB register:
  - Captures the writeback mux on the completion edge: non-stalled cycle, or the ready cycle.
  - Latency: 1 cycle from completion to wb_* outputs.
  - During stall cycles wb_reg_write_o=0, so no duplicate writes.
- rd=0: wb_reg_write_o still driven as decoded; the register file ignores x0.
- dmem_ready_i while dmem_req_o=0 is ignored.
- Reset asserted in WAIT: immediate return to IDLE, request dropped, outputs 0.

Decomposition:
- Package cpu_mem_pkg holds:
  - width codes: W_BYTE, W_HALF, W_WORD
  - reg_src codes: SRC_ALU, SRC_MEM, SRC_PC
  - FSM state enum
  - TIMEOUT counter width constant (10 bits)
- One combinational sub-module, mem_lane_align: byte-enable generation, store replication, load extract/extend, misalign detect.
- FSM, counter and MEM/WB register stay in the top.

Test Plan:
- Load byte, addr 0x103, rdata 0x80FF_1234, sign=1, ready same cycle -> no stall; next cycle wb_data=0xFFFF_FF80, wb_reg_write=1.
- Store half, addr 0x202, rs2=0x0000_ABCD, ready after 3 cycles:
  - dmem_be=1100, wdata=0xABCD_ABCD, we=1.
  - stall_o high for 3 cycles.
  - wb_reg_write=0 throughout.
- Load word, addr 0x101 -> misalign_o pulse, no req, no stall, wb_reg_write=0.
- TIMEOUT=4, load with ready never asserted:
  - stall for 4 cycles, then bus_err_o=1, stall_o=0, wb_reg_write=0.
  - bus_err_o stays 1 until rst_n low.
- JAL bubble-free: reg_src=10, advance_pc=0x0000_0048, rd=1 -> next cycle wb_data=0x48, wb_addr=1, no dmem_req.
- rst_n low mid-WAIT -> dmem_req_o, stall_o, wb_* immediately 0; after release, IDLE accepts a fresh load.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory stage: access widths, writeback
// source select, the handshake FSM states and the wait-counter width.
package cpu_mem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  // Ten bits covers the largest permitted wait limit of 1023 cycles.
  localparam int CNT_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational lane steering between the 32-bit data bus and
// byte/half/word accesses: byte enables, store replication, load
// extraction with optional sign extension, and misalignment detection.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  addr_low,
  input  logic [1:0]  width,
  input  logic        sign_extend,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byte_en,
  output logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte enables follow the address; half and word must be naturally aligned,
  // and the unused width code is always treated as an illegal access.
  always_comb begin
    byte_en    = 4'b0000;
    misaligned = 1'b0;
    case (width)
      W_BYTE: byte_en = 4'b0001 << addr_low;
      W_HALF: begin
        byte_en    = addr_low[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_low[0];
      end
      W_WORD: begin
        byte_en    = 4'b1111;
        misaligned = (addr_low != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Replicate narrow store data into every lane so the memory can pick
  // whichever lane the byte enables select.
  always_comb begin
    case (width)
      W_BYTE:  write_data = {4{store_data[7:0]}};
      W_HALF:  write_data = {2{store_data[15:0]}};
      default: write_data = store_data;
    endcase
  end

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    case (addr_low)
      2'b00:   byte_lane = read_data[7:0];
      2'b01:   byte_lane = read_data[15:8];
      2'b10:   byte_lane = read_data[23:16];
      default: byte_lane = read_data[31:24];
    endcase
    half_lane = addr_low[1] ? read_data[31:16] : read_data[15:0];
  end

  // Extend the selected lane to 32 bits; word loads pass through untouched.
  always_comb begin
    case (width)
      W_BYTE:  load_data = sign_extend ? {{24{byte_lane[7]}}, byte_lane}
                                       : {24'h000000, byte_lane};
      W_HALF:  load_data = sign_extend ? {{16{half_lane[15]}}, half_lane}
                                       : {16'h0000, half_lane};
      default: load_data = read_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. Issues data-memory
// requests, holds the upstream pipeline while memory is busy, aborts
// accesses that exceed TIMEOUT cycles, and registers the writeback result.
module mem_wb_stage
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] advance_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] reg_2_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_write_data_addr_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_extend_i,
  input  logic [1:0]  reg_src_i,
  input  logic        mem_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  logic        mem_op;
  logic        misaligned;
  logic        commit;
  logic        wb_we_next;
  logic        abort;
  logic [3:0]  be_raw;
  logic [31:0] load_data;
  logic [31:0] wb_mux;

  assign mem_op      = mem_write_i | (reg_src_i == SRC_MEM);
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
  assign dmem_we_o   = dmem_req_o & mem_write_i;
  assign dmem_be_o   = dmem_req_o ? be_raw : 4'b0000;

  mem_lane_align u_align (
    .addr_low    (alu_result_i[1:0]),
    .width       (mem_width_i),
    .sign_extend (mem_sign_extend_i),
    .store_data  (reg_2_data_i),
    .read_data   (dmem_rdata_i),
    .byte_en     (be_raw),
    .write_data  (dmem_wdata_o),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // Select what the instruction writes back to the register file.
  always_comb begin
    case (reg_src_i)
      SRC_ALU: wb_mux = alu_result_i;
      SRC_MEM: wb_mux = load_data;
      SRC_PC:  wb_mux = advance_pc_i;
      default: wb_mux = alu_result_i;
    endcase
  end

  // Handshake FSM: decides request, stall, completion and abort each cycle.
  // Everything is forced low while reset is held so the bus drops at once.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    dmem_req_o    = 1'b0;
    stall_o       = 1'b0;
    misalign_o    = 1'b0;
    commit        = 1'b0;
    wb_we_next    = 1'b0;
    abort         = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (!mem_op) begin
            commit     = 1'b1;
            wb_we_next = reg_write_i;
          end else if (misaligned) begin
            misalign_o = 1'b1;
            commit     = 1'b1;
          end else begin
            dmem_req_o = 1'b1;
            if (dmem_ready_i) begin
              commit     = 1'b1;
              wb_we_next = reg_write_i;
            end else begin
              stall_o       = 1'b1;
              state_next    = ST_WAIT;
              wait_cnt_next = CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          dmem_req_o = 1'b1;
          if (dmem_ready_i) begin
            commit        = 1'b1;
            wb_we_next    = reg_write_i;
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            abort         = 1'b1;
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
          end else begin
            stall_o       = 1'b1;
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next    = ST_IDLE;
          wait_cnt_next = '0;
        end
      endcase
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // MEM/WB register: data and rd load only when an instruction completes;
  // the write enable is cleared on stall, abort and misaligned cycles so an
  // instruction is never written twice or written with bad data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg_write_o <= 1'b0;
      wb_addr_o      <= 5'd0;
      wb_data_o      <= 32'h0000_0000;
    end else begin
      wb_reg_write_o <= wb_we_next;
      if (commit) begin
        wb_addr_o <= reg_write_data_addr_i;
        wb_data_o <= wb_mux;
      end
    end
  end

  // Sticky bus-error flag raised by a timed-out access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_o <= 1'b0;
    end else if (abort) begin
      bus_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs change on the falling edge,
// combinational outputs are checked 1ns later, registered outputs 1ns
// after the following rising edge.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] advance_pc;
  logic [31:0] alu_result;
  logic [31:0] reg_2_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [1:0]  mem_width;
  logic        mem_sign_extend;
  logic [1:0]  reg_src;
  logic        mem_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .advance_pc_i          (advance_pc),
    .alu_result_i          (alu_result),
    .reg_2_data_i          (reg_2_data),
    .reg_write_i           (reg_write),
    .reg_write_data_addr_i (rd),
    .mem_width_i           (mem_width),
    .mem_sign_extend_i     (mem_sign_extend),
    .reg_src_i             (reg_src),
    .mem_write_i           (mem_write),
    .dmem_req_o            (dmem_req),
    .dmem_we_o             (dmem_we),
    .dmem_addr_o           (dmem_addr),
    .dmem_be_o             (dmem_be),
    .dmem_wdata_o          (dmem_wdata),
    .dmem_ready_i          (dmem_ready),
    .dmem_rdata_i          (dmem_rdata),
    .stall_o               (stall),
    .wb_reg_write_o        (wb_reg_write),
    .wb_addr_o             (wb_addr),
    .wb_data_o             (wb_data),
    .misalign_o            (misalign),
    .bus_err_o             (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_op(input logic [1:0] src, input logic wr, input logic rw,
                          input logic [1:0] w, input logic sx, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] dst,
                          input logic [31:0] pc);
    reg_src         = src;
    mem_write       = wr;
    reg_write       = rw;
    mem_width       = w;
    mem_sign_extend = sx;
    alu_result      = alu;
    reg_2_data      = rs2;
    rd              = dst;
    advance_pc      = pc;
  endtask

  task automatic drive_bubble();
    drive_op(2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_bubble();
    #12;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL rst_req: got %b expected 0", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL rst_stall: got %b expected 0", stall); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL rst_wb_we: got %b expected 0", wb_reg_write); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("[TB] FAIL rst_wb_data: got %h expected 0", wb_data); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_bus_err: got %b expected 0", bus_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    @(negedge clk);
    drive_op(2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd5, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_1234;
    #1;
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("[TB] FAIL lb_req: got %b expected 1", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL lb_stall: got %b expected 0", stall); end
    n_cmp++; if (dmem_be !== 4'b1000) begin n_err++; $display("[TB] FAIL lb_be: got %b expected 1000", dmem_be); end
    n_cmp++; if (dmem_addr !== 32'h0000_0100) begin n_err++; $display("[TB] FAIL lb_addr: got %h expected 00000100", dmem_addr); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_err++; $display("[TB] FAIL lb_we: got %b expected 0", dmem_we); end
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'hFFFF_FF80) begin n_err++; $display("[TB] FAIL lb_wb_data: got %h expected ffffff80", wb_data); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_err++; $display("[TB] FAIL lb_wb_we: got %b expected 1", wb_reg_write); end
    n_cmp++; if (wb_addr !== 5'd5) begin n_err++; $display("[TB] FAIL lb_wb_addr: got %0d expected 5", wb_addr); end
  endtask

  task automatic test_back_to_back();
    // Unsigned upper half, then signed lower half, then a plain ALU result.
    @(negedge clk);
    drive_op(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_1234;
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'h0000_80FF) begin n_err++; $display("[TB] FAIL lhu_wb_data: got %h expected 000080ff", wb_data); end
    @(negedge clk);
    drive_op(2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 32'h0);
    dmem_rdata = 32'h0000_8001;
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'hFFFF_8001) begin n_err++; $display("[TB] FAIL lh_wb_data: got %h expected ffff8001", wb_data); end
    n_cmp++; if (wb_addr !== 5'd7) begin n_err++; $display("[TB] FAIL lh_wb_addr: got %0d expected 7", wb_addr); end
    @(negedge clk);
    drive_op(2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd3, 32'h0);
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL alu_req: got %b expected 0", dmem_req); end
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL alu_wb_data: got %h expected deadbeef", wb_data); end
  endtask

  task automatic test_store_half();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_op(2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 32'h0);
      dmem_ready = (i == 3);
      #1;
      n_cmp++; if (stall !== (i < 3)) begin n_err++; $display("[TB] FAIL sh_stall[%0d]: got %b expected %b", i, stall, (i < 3)); end
      n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("[TB] FAIL sh_req[%0d]: got %b expected 1", i, dmem_req); end
      n_cmp++; if (dmem_be !== 4'b1100) begin n_err++; $display("[TB] FAIL sh_be[%0d]: got %b expected 1100", i, dmem_be); end
      n_cmp++; if (dmem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("[TB] FAIL sh_wdata[%0d]: got %h expected abcdabcd", i, dmem_wdata); end
      n_cmp++; if (dmem_we !== 1'b1) begin n_err++; $display("[TB] FAIL sh_we[%0d]: got %b expected 1", i, dmem_we); end
      @(posedge clk); #1;
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL sh_wb_we[%0d]: got %b expected 0", i, wb_reg_write); end
    end
    @(negedge clk);
    drive_bubble();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL sh_after_stall: got %b expected 0", stall); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_op(2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd9, 32'h0);
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("[TB] FAIL mis_pulse: got %b expected 1", misalign); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL mis_req: got %b expected 0", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL mis_stall: got %b expected 0", stall); end
    n_cmp++; if (dmem_be !== 4'b0000) begin n_err++; $display("[TB] FAIL mis_be: got %b expected 0000", dmem_be); end
    @(posedge clk); #1;
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL mis_wb_we: got %b expected 0", wb_reg_write); end
    @(negedge clk);
    drive_bubble();
    #1;
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("[TB] FAIL mis_end: got %b expected 0", misalign); end
  endtask

  task automatic test_jal();
    @(negedge clk);
    drive_op(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 5'd1, 32'h0000_0048);
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL jal_req: got %b expected 0", dmem_req); end
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'h0000_0048) begin n_err++; $display("[TB] FAIL jal_wb_data: got %h expected 00000048", wb_data); end
    n_cmp++; if (wb_addr !== 5'd1) begin n_err++; $display("[TB] FAIL jal_wb_addr: got %0d expected 1", wb_addr); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_err++; $display("[TB] FAIL jal_wb_we: got %b expected 1", wb_reg_write); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_op(2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd4, 32'h0);
      dmem_ready = 1'b0;
      #1;
      n_cmp++; if (stall !== (i < 4)) begin n_err++; $display("[TB] FAIL to_stall[%0d]: got %b expected %b", i, stall, (i < 4)); end
      n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("[TB] FAIL to_err_early[%0d]: got %b expected 0", i, bus_err); end
      @(posedge clk); #1;
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL to_wb_we[%0d]: got %b expected 0", i, wb_reg_write); end
    end
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("[TB] FAIL to_err_set: got %b expected 1", bus_err); end
    // Ready without a request must be ignored; the error flag stays set.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_bubble();
      dmem_ready = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL to_idle_stall[%0d]: got %b expected 0", i, stall); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL to_idle_req[%0d]: got %b expected 0", i, dmem_req); end
      @(posedge clk); #1;
      n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("[TB] FAIL to_err_sticky[%0d]: got %b expected 1", i, bus_err); end
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL to_idle_wb_we[%0d]: got %b expected 0", i, wb_reg_write); end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_op(2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd8, 32'h0);
    dmem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_req: got %b expected 0", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_stall: got %b expected 0", stall); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_wb_we: got %b expected 0", wb_reg_write); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("[TB] FAIL mrst_wb_data: got %h expected 0", wb_data); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_bus_err: got %b expected 0", bus_err); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 5'd7, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("[TB] FAIL fresh_req: got %b expected 1", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL fresh_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'h1234_5678) begin n_err++; $display("[TB] FAIL fresh_wb_data: got %h expected 12345678", wb_data); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_err++; $display("[TB] FAIL fresh_wb_we: got %b expected 1", wb_reg_write); end
    @(negedge clk);
    drive_bubble();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_back_to_back();
    test_store_half();
    test_misalign();
    test_jal();
    test_timeout();
    test_reset_mid_wait();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
